// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_scanner
// Brief    : Column-scanned driver for a 5x7 LED matrix. Mirrors three column
//            patterns onto five columns; latches the image once per frame.
//            Define MATRIX_SCAN_BLANK_EN to insert an all-off cycle between columns.
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scanner #(
    parameter int DWELL = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] col_2,
    input  logic [6:0] col_1,
    input  logic [6:0] col_0,
    output logic [4:0] col_sel_n,
    output logic [6:0] row,
    output logic       frame_done
);

    localparam int             CW          = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  c_dwell_last = CW'(DWELL - 1);
    localparam logic [4:0]     c_sel_off    = 5'b11111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_DRIVE = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_col;
    logic [CW-1:0]   r_dwell;
    logic [6:0]      r_sh2;
    logic [6:0]      r_sh1;
    logic [6:0]      r_sh0;
    logic [2:0]      w_next_col;

    assign w_next_col = r_col + 3'd1;

    function automatic logic [6:0] pick(input logic [2:0] k, input logic [6:0] a2,
                                        input logic [6:0] a1, input logic [6:0] a0);
        case (k)
            3'd1, 3'd3: return a1;
            3'd2:       return a0;
            default:    return a2;
        endcase
    endfunction

    function automatic logic [4:0] sel_n(input logic [2:0] k);
        return ~(5'b00001 << k);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_col      <= 3'd0;
            r_dwell    <= '0;
            r_sh2      <= 7'd0;
            r_sh1      <= 7'd0;
            r_sh0      <= 7'd0;
            col_sel_n  <= c_sel_off;
            row        <= 7'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!enable) begin
                // Any disable abandons the frame; re-enable restarts from LATCH.
                r_state   <= S_IDLE;
                r_col     <= 3'd0;
                r_dwell   <= '0;
                col_sel_n <= c_sel_off;
                row       <= 7'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_LATCH;
                        col_sel_n <= c_sel_off;
                        row       <= 7'd0;
                    end
                    S_LATCH: begin
                        r_sh2     <= col_2;
                        r_sh1     <= col_1;
                        r_sh0     <= col_0;
                        r_col     <= 3'd0;
                        r_dwell   <= '0;
                        r_state   <= S_DRIVE;
                        col_sel_n <= sel_n(3'd0);
                        // Same value being captured into r_sh2 on this edge.
                        row       <= col_2;
                    end
                    S_DRIVE: begin
                        if (r_dwell == c_dwell_last) begin
                            r_dwell <= '0;
                            if (r_col == 3'd4) begin
                                r_state    <= S_LATCH;
                                frame_done <= 1'b1;
                                col_sel_n  <= c_sel_off;
                                row        <= 7'd0;
                            end else begin
                                r_col <= w_next_col;
`ifdef MATRIX_SCAN_BLANK_EN
                                r_state   <= S_BLANK;
                                col_sel_n <= c_sel_off;
                                row       <= 7'd0;
`else
                                col_sel_n <= sel_n(w_next_col);
                                row       <= pick(w_next_col, r_sh2, r_sh1, r_sh0);
`endif
                            end
                        end else begin
                            r_dwell <= r_dwell + CW'(1);
                        end
                    end
                    S_BLANK: begin
                        r_state   <= S_DRIVE;
                        col_sel_n <= sel_n(r_col);
                        row       <= pick(r_col, r_sh2, r_sh1, r_sh0);
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        col_sel_n <= c_sel_off;
                        row       <= 7'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_matrix_scanner
// Brief    : Directed self-checking bench for led_matrix_scanner (DWELL=4 and DWELL=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_a = 1'b0;
    logic       enable_b = 1'b0;
    logic [6:0] col_2 = 7'h41;
    logic [6:0] col_1 = 7'h1C;
    logic [6:0] col_0 = 7'h7F;
    logic [4:0] sel_a, sel_b;
    logic [6:0] row_a, row_b;
    logic       fd_a, fd_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    led_matrix_scanner #(.DWELL(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a),
        .col_2(col_2), .col_1(col_1), .col_0(col_0),
        .col_sel_n(sel_a), .row(row_a), .frame_done(fd_a)
    );

    led_matrix_scanner #(.DWELL(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b),
        .col_2(col_2), .col_1(col_1), .col_0(col_0),
        .col_sel_n(sel_b), .row(row_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [6:0] exp_row(input int k, input logic [6:0] p2,
                                           input logic [6:0] p1, input logic [6:0] p0);
        case (k)
            1, 3:    return p1;
            2:       return p0;
            default: return p2;
        endcase
    endfunction

    function automatic logic [4:0] exp_sel(input int k);
        logic [4:0] s;
        s = 5'b11111;
        s[k] = 1'b0;
        return s;
    endfunction

    // Called on the first cycle of column 0; ends on the frame_done/LATCH cycle,
    // or after disabling at column stop_col.
    task automatic walk_a(input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0,
                          input bit chg, input int stop_col);
        for (int k = 0; k < 5; k++) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("a_sel_c%0d_d%0d", k, d), sel_a, exp_sel(k));
                chk($sformatf("a_row_c%0d_d%0d", k, d), row_a, exp_row(k, p2, p1, p0));
                chk($sformatf("a_fd_c%0d_d%0d", k, d), fd_a, 0);
                if (chg && k == 1 && d == 0) col_0 = 7'h00;
                if (k == stop_col && d == 1) begin
                    enable_a = 1'b0;
                    tick(1);
                    chk("a_dis_sel", sel_a, 5'h1F);
                    chk("a_dis_row", row_a, 0);
                    chk("a_dis_fd", fd_a, 0);
                    for (int i = 0; i < 8; i++) begin
                        tick(1);
                        chk($sformatf("a_idle_fd_%0d", i), fd_a, 0);
                        chk($sformatf("a_idle_sel_%0d", i), sel_a, 5'h1F);
                    end
                    return;
                end
                tick(1);
            end
`ifdef MATRIX_SCAN_BLANK_EN
            if (k < 4) begin
                chk($sformatf("a_blank_sel_%0d", k), sel_a, 5'h1F);
                chk($sformatf("a_blank_row_%0d", k), row_a, 0);
                tick(1);
            end
`endif
        end
        chk("a_frame_done", fd_a, 1);
        chk("a_latch_sel", sel_a, 5'h1F);
        chk("a_latch_row", row_a, 0);
    endtask

    initial begin
        // Reset values
        tick(2);
        chk("rst_sel_a", sel_a, 5'h1F);
        chk("rst_row_a", row_a, 0);
        chk("rst_fd_a", fd_a, 0);
        chk("rst_sel_b", sel_b, 5'h1F);
        chk("rst_row_b", row_b, 0);
        chk("rst_fd_b", fd_b, 0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_sel_a", sel_a, 5'h1F);

        // Enable: one LATCH cycle, then column 0
        enable_a = 1'b1;
        tick(1);
        chk("latch_sel_a", sel_a, 5'h1F);
        chk("latch_row_a", row_a, 0);
        chk("latch_fd_a", fd_a, 0);
        tick(1);
        walk_a(7'h41, 7'h1C, 7'h7F, 1'b0, 5);
        tick(1);
        // col_0 changes during column 1: this frame still shows 7F
        walk_a(7'h41, 7'h1C, 7'h7F, 1'b1, 5);
        tick(1);
        // New image visible; disable during column 3
        walk_a(7'h41, 7'h1C, 7'h00, 1'b0, 3);

        // Re-enable restarts from LATCH at column 0
        enable_a = 1'b1;
        tick(1);
        chk("reen_latch_sel", sel_a, 5'h1F);
        chk("reen_latch_fd", fd_a, 0);
        tick(1);
        walk_a(7'h41, 7'h1C, 7'h00, 1'b0, 5);

        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (fd_a !== 1'b1 && cnt < 200);
`ifdef MATRIX_SCAN_BLANK_EN
        chk("a_period", cnt, 25);
`else
        chk("a_period", cnt, 21);
`endif

        // Minimum dwell instance
        enable_b = 1'b1;
        tick(1);
        chk("b_latch_sel", sel_b, 5'h1F);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("b_sel_c%0d_d%0d", k, d), sel_b, exp_sel(k));
                chk($sformatf("b_row_c%0d_d%0d", k, d), row_b, exp_row(k, 7'h41, 7'h1C, 7'h00));
                tick(1);
            end
`ifdef MATRIX_SCAN_BLANK_EN
            if (k < 4) begin
                chk($sformatf("b_blank_sel_%0d", k), sel_b, 5'h1F);
                tick(1);
            end
`endif
        end
        chk("b_frame_done", fd_b, 1);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (fd_b !== 1'b1 && cnt < 200);
`ifdef MATRIX_SCAN_BLANK_EN
        chk("b_period", cnt, 15);
`else
        chk("b_period", cnt, 11);
`endif

        // Asynchronous reset mid-DRIVE, checked between clock edges
        tick(1);
        chk("b_pre_rst_sel", sel_b, 5'h1E);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel_a", sel_a, 5'h1F);
        chk("arst_row_a", row_a, 0);
        chk("arst_fd_a", fd_a, 0);
        chk("arst_sel_b", sel_b, 5'h1F);
        chk("arst_row_b", row_b, 0);
        chk("arst_fd_b", fd_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
